// File: rtl/uart_rs232_tx_if.sv
// Transmit-side bus of the RS-232 UART: request, frame config, line and status.
// master drives requests; slave is the transmitter.
interface uart_rs232_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] bits;
  logic       parity_en;
  logic       parity_odd;
  logic       two_stop;
  logic       tx_port;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    output bits,
    output parity_en,
    output parity_odd,
    output two_stop,
    input  tx_port,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    input  bits,
    input  parity_en,
    input  parity_odd,
    input  two_stop,
    output tx_port,
    output tx_busy,
    output tx_done
  );
endinterface

// File: rtl/uart_rs232_tx.sv
// RS-232 frame transmitter: start, 6-8 data bits LSB first, optional parity,
// one or two stop bits, paced by an oversampling tick enable.
module uart_rs232_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           rst_n_a,
  input  logic           tick,
  uart_rs232_tx_if.slave bus
);

  localparam int CW =
    ($clog2(OVERSAMPLE) < 1) ? 1 : $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] TLAST = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] tcnt;
  logic [2:0]    idx;
  logic          stop2;
  logic [7:0]    data_q;
  logic [3:0]    nbits_q;
  logic          pen_q;
  logic          podd_q;
  logic          two_q;
  logic          port_q;
  logic          busy_q;
  logic          done_q;

  logic          bit_end;
  logic          last_data;
  logic [7:0]    mask;
  logic          par;
  logic [3:0]    nbits_in;

  always_comb begin
    bit_end   = tick && (tcnt == TLAST);
    last_data = ({1'b0, idx} == (nbits_q - 4'd1));
    mask      = 8'hFF;
    unique case (1'b1)
      nbits_q == 4'd6: mask = 8'h3F;
      nbits_q == 4'd7: mask = 8'h7F;
      default: ;
    endcase
    // unsent upper bits are masked out of the parity
    par = (^(data_q & mask)) ^ podd_q;
    nbits_in = 4'd8;
    unique case (1'b1)
      bus.bits == 4'd6: nbits_in = 4'd6;
      bus.bits == 4'd7: nbits_in = 4'd7;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_a) begin
    if (!rst_n_a) begin
      state   <= IDLE;
      tcnt    <= '0;
      idx     <= '0;
      stop2   <= 1'b0;
      data_q  <= '0;
      nbits_q <= '0;
      pen_q   <= 1'b0;
      podd_q  <= 1'b0;
      two_q   <= 1'b0;
      port_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE && tick)
        tcnt <= bit_end ? '0 : tcnt + CW'(1);
      unique case (state)
        IDLE: begin
          tcnt <= '0;
          if (bus.tx_start) begin
            data_q  <= bus.tx_data;
            nbits_q <= nbits_in;
            pen_q   <= bus.parity_en;
            podd_q  <= bus.parity_odd;
            two_q   <= bus.two_stop;
            idx     <= '0;
            stop2   <= 1'b0;
            state   <= START;
            port_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            idx    <= '0;
            port_q <= data_q[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (last_data) begin
              if (pen_q) begin
                state  <= PARITY;
                port_q <= par;
              end else begin
                state  <= STOP;
                port_q <= 1'b1;
                stop2  <= 1'b0;
              end
            end else begin
              idx    <= idx + 3'd1;
              port_q <= data_q[idx + 3'd1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state  <= STOP;
            port_q <= 1'b1;
            stop2  <= 1'b0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (two_q && !stop2) begin
              stop2 <= 1'b1;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_port = port_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_rs232_tx.sv
// Bench for uart_rs232_tx: random tick pacing, frame model built from
// the line format, directed and random frames.
module tb_uart_rs232_tx;

  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst_n_a = 1'b1;
  logic tick = 1'b0;
  int   total = 0;
  int   bad = 0;

  uart_rs232_tx_if bus ();

  uart_rs232_tx #(.OVERSAMPLE(16)) dut (
    .clk     (clk),
    .rst_n_a (rst_n_a),
    .tick    (tick),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1 tick = !tick && ($urandom_range(0, 2) == 0);
    end
  end

  function automatic bq_t build(input logic [7:0] d, input int b,
                                input bit pe, input bit po, input bit ts);
    bq_t q;
    int  n;
    int  ones;
    ones = 0;
    n = (b == 6 || b == 7) ? b : 8;
    q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (pe) q.push_back(bit'(ones % 2) ^ po);
    q.push_back(1'b1);
    if (ts) q.push_back(1'b1);
    return q;
  endfunction

  task automatic launch(input logic [7:0] d, input logic [3:0] b,
                        input bit pe, input bit po, input bit ts);
    @(negedge clk);
    bus.tx_data    = d;
    bus.bits       = b;
    bus.parity_en  = pe;
    bus.parity_odd = po;
    bus.two_stop   = ts;
    bus.tx_start   = 1'b1;
  endtask

  task automatic watch(input string nm, input bq_t seq, input bit keep,
                       input bit post, input int mid, input int abort_at);
    int cnt;
    int lim;
    cnt = 0;
    lim = seq.size() * 16;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (!keep) bus.tx_start = 1'b0;
      if (cnt == abort_at) begin
        rst_n_a = 1'b0;
        #1;
        total++;
        if (bus.tx_port !== 1'b1 || bus.tx_busy !== 1'b0 ||
            bus.tx_done !== 1'b0) begin
          bad++;
          $display("FAIL %s async_reset: port=%b busy=%b done=%b want 1 0 0",
                   nm, bus.tx_port, bus.tx_busy, bus.tx_done);
        end
        return;
      end
      if (cnt == lim) begin
        total++;
        if (bus.tx_done !== 1'b1 || bus.tx_busy !== 1'b0 ||
            bus.tx_port !== 1'b1) begin
          bad++;
          $display("FAIL %s frame_end: done=%b busy=%b port=%b want 1 0 1",
                   nm, bus.tx_done, bus.tx_busy, bus.tx_port);
        end
        if (post) begin
          @(negedge clk);
          total++;
          if (bus.tx_done !== 1'b0 || bus.tx_busy !== 1'b0 ||
              bus.tx_port !== 1'b1) begin
            bad++;
            $display("FAIL %s after_end: done=%b busy=%b port=%b want 0 0 1",
                     nm, bus.tx_done, bus.tx_busy, bus.tx_port);
          end
        end
        return;
      end
      total++;
      if (bus.tx_port !== seq[cnt/16] || bus.tx_busy !== 1'b1 ||
          bus.tx_done !== 1'b0) begin
        bad++;
        if (bad < 40)
          $display("FAIL %s bit%0d tick%0d: port=%b busy=%b done=%b want %b 1 0",
                   nm, cnt / 16, cnt, bus.tx_port, bus.tx_busy,
                   bus.tx_done, seq[cnt/16]);
      end
      if (mid >= 0 && cnt == mid) begin
        bus.tx_start   = 1'b1;
        bus.tx_data    = 8'hFF;
        bus.bits       = 4'd6;
        bus.parity_en  = ~bus.parity_en;
        bus.parity_odd = ~bus.parity_odd;
        bus.two_stop   = ~bus.two_stop;
      end
      if (tick) cnt++;
    end
    total++;
    bad++;
    $display("FAIL %s timeout at tick %0d of %0d", nm, cnt, lim);
  endtask

  task automatic test_reset;
    #1 rst_n_a = 1'b0;
    #1;
    total++;
    if (bus.tx_port !== 1'b1 || bus.tx_busy !== 1'b0 ||
        bus.tx_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: port=%b busy=%b done=%b want 1 0 0",
               bus.tx_port, bus.tx_busy, bus.tx_done);
    end
    repeat (4) @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  task automatic test_idle_ticks;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (bus.tx_port !== 1'b1 || bus.tx_busy !== 1'b0 ||
          bus.tx_done !== 1'b0) begin
        bad++;
        $display("FAIL idle_%0d: port=%b busy=%b done=%b want 1 0 0",
                 i, bus.tx_port, bus.tx_busy, bus.tx_done);
      end
    end
  endtask

  task automatic test_frame_55;
    launch(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
    watch("f55", build(8'h55, 8, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_frame_a3;
    launch(8'hA3, 4'd7, 1'b1, 1'b0, 1'b0);
    watch("fa3", build(8'hA3, 7, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_frame_3f;
    launch(8'h3F, 4'd6, 1'b1, 1'b1, 1'b1);
    watch("f3f", build(8'h3F, 6, 1'b1, 1'b1, 1'b1), 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_ignore_start;
    launch(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
    watch("ignore", build(8'h55, 8, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, 40, -1);
  endtask

  task automatic test_reset_mid;
    launch(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
    watch("rst_mid", build(8'h55, 8, 1'b0, 1'b0, 1'b0), 1'b0, 1'b0,
          -1, 16 * 4 + 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (bus.tx_port !== 1'b1 || bus.tx_busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_hold_%0d: port=%b busy=%b want 1 0",
                 i, bus.tx_port, bus.tx_busy);
      end
    end
    @(negedge clk);
    rst_n_a        = 1'b1;
    bus.tx_data    = 8'h81;
    bus.bits       = 4'd8;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.two_stop   = 1'b0;
    bus.tx_start   = 1'b1;
    watch("f81", build(8'h81, 8, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_back_to_back;
    launch(8'h55, 4'd8, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 bus.tx_data = 8'hAA;
    watch("b2b_1", build(8'h55, 8, 1'b0, 1'b0, 1'b0), 1'b1, 1'b0, -1, -1);
    watch("b2b_2", build(8'hAA, 8, 1'b0, 1'b0, 1'b0), 1'b0, 1'b1, -1, -1);
  endtask

  task automatic test_random;
    logic [7:0] d;
    logic [3:0] b;
    bit pe, po, ts;
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom);
      b  = 4'($urandom_range(0, 15));
      pe = 1'($urandom);
      po = 1'($urandom);
      ts = 1'($urandom);
      launch(d, b, pe, po, ts);
      watch($sformatf("rnd%0d_%02h_b%0d", i, d, b),
            build(d, int'(b), pe, po, ts), 1'b0, 1'b1, -1, -1);
    end
  endtask

  initial begin
    bus.tx_start   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.bits       = 4'd8;
    bus.parity_en  = 1'b0;
    bus.parity_odd = 1'b0;
    bus.two_stop   = 1'b0;
    test_reset;
    test_idle_ticks;
    test_frame_55;
    test_frame_a3;
    test_frame_3f;
    test_ignore_start;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rs232_tx.md
UART_RS232_TX -- requirements
Module: uart_rs232_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16: tick pulses per serial bit period.
REQ-002 SHALL have clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have rst_n_a  input  1  asynchronous, active-low reset.
REQ-004 SHALL have tick  input  1  baud enable, one clk wide, OVERSAMPLE per bit period.
REQ-005 SHALL have tx_start  input  1  request to send tx_data; sampled only in IDLE.
REQ-006 SHALL have tx_data  input  8  frame payload, LSB sent first.
REQ-007 SHALL have bits  input  4  data bits per frame: 6, 7 or 8; any other value treated as 8.
REQ-008 SHALL have parity_en  input  1  1 = insert parity bit after data.
REQ-009 SHALL have parity_odd  input  1  1 = odd parity, 0 = even parity.
REQ-010 SHALL have two_stop  input  1  1 = two stop bits, 0 = one stop bit.
REQ-011 SHALL have tx_port  output  1  serial line, registered, idle high.
REQ-012 SHALL have tx_busy  output  1  high from acceptance until frame end.
REQ-013 SHALL have tx_done  output  1  one-clk pulse at frame end.

Function
REQ-014 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-015 SHALL, in IDLE with tx_start=1, latch tx_data, bits, parity_en, parity_odd, two_stop on that edge and enter START; tx_busy=1 and tx_port=0 from the next cycle.
REQ-016 SHALL ignore tx_start outside IDLE; latched config changes mid-frame have no effect.
REQ-017 SHALL hold the 4-bit-wide-enough tick counter at 0 in IDLE and ignore tick there.
REQ-018 SHALL count tick pulses per bit; bit ends on the OVERSAMPLE-th tick, counter wraps to 0, next bit's value driven on the following clk.
REQ-019 SHALL, in START, drive tx_port=0 for one bit period, then enter DATA.
REQ-020 SHALL, in DATA, drive latched bit 0 upward, one bit period each, for N = latched bits; then PARITY if parity_en else STOP.
REQ-021 SHALL, in PARITY, drive XOR of the N transmitted data bits (unsent upper bits excluded), inverted when parity_odd=1, for one bit period.
REQ-022 SHALL, in STOP, drive tx_port=1 for one bit period (two when two_stop=1).
REQ-023 SHALL, on the clk after the final stop tick, return to IDLE, tx_busy=0, tx_done=1 for exactly that cycle.
REQ-024 SHALL accept tx_start in the tx_done cycle, giving back-to-back frames with no idle gap.
REQ-025 SHALL never glitch tx_port; it changes only at bit boundaries or on reset.

Reset
REQ-026 SHALL, while rst_n_a=0, force state IDLE, tx_port=1, tx_busy=0, tx_done=0, counters and latched data 0, independent of clk.
REQ-027 SHALL abandon any frame in progress on reset; no partial frame resumes after release.
REQ-028 SHALL accept tx_start on the first clk edge after rst_n_a deasserts.

Verification
REQ-029 SHALL cover: tx_data=0x55, bits=8, no parity, 1 stop -> tx_port 0,1,0,1,0,1,0,1,0,1, 16 ticks each; tx_done after 160 ticks.
REQ-030 SHALL cover: tx_data=0xA3, bits=7, even parity -> 0,1,1,0,0,0,1,0,1(parity),1; 160 ticks.
REQ-031 SHALL cover: tx_data=0x3F, bits=6, odd parity, two_stop -> 0,1,1,1,1,1,1,1(parity),1,1; 160 ticks.
REQ-032 SHALL cover: tx_start with 0xFF pulsed mid-frame of 0x55 -> ignored; 0x55 frame intact, single tx_done.
REQ-033 SHALL cover: rst_n_a low during DATA bit 3 -> tx_port=1, tx_busy=0 immediately; next frame 0x81 bit-exact.
REQ-034 SHALL cover: tx_start held high, 0x55 then 0xAA -> start bit of frame 2 directly follows stop of frame 1; 320 ticks, two tx_done pulses.
